cdc_stream_gen: RTL and testbench

- Ingress-side traffic source (writer) for the CDC FIFO path. Lives entirely in the clk_a domain.
- Produces paced bursts of data_valid_a/data_a beats with a known data sequence, so the egress side can be checked beat-for-beat.
- Burst length, gap length and burst count are runtime inputs latched at start.
- Provides busy/done status and a beat counter for the bench.

---
 rtl/cdc_pkg.sv | 16 +
 rtl/cdc_lfsr.sv | 31 +++
 rtl/cdc_stream_gen.sv | 196 +++++++++++++++++++
 tb/tb_cdc_stream_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and PRBS31 constants for the CDC stream generator/checker path.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  localparam int unsigned PRBS31_LEN  = 31;
  // x^31 + x^28 + 1 -> feedback from bits 30 and 27
  localparam logic [30:0] PRBS31_TAPS = 31'h4800_0000;
  localparam logic [30:0] PRBS31_SEED = 31'h0000_0001;

endpackage

// File: rtl/cdc_lfsr.sv
// Fibonacci LFSR with load and advance; shifts left, feedback enters at bit 0.
module cdc_lfsr #(
  parameter int unsigned      LEN  = 31,
  parameter logic [LEN-1:0]   TAPS = LEN'(31'h4800_0000),
  parameter logic [LEN-1:0]   SEED = LEN'(1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [LEN-1:0] i_seed,
  input  logic           i_advance,
  output logic [LEN-1:0] o_state
);

  logic [LEN-1:0] r_state;
  logic           w_fb;

  assign w_fb    = ^(r_state & TAPS);
  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_advance) begin
      r_state <= {r_state[LEN-2:0], w_fb};
    end
  end

endmodule

// File: rtl/cdc_stream_gen.sv
// Paced burst traffic source for the CDC FIFO ingress (clk_a domain).
// Optional PRBS31 data mode is built only when CDC_GEN_PRBS_EN is defined.
module cdc_stream_gen
  import cdc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] DATA_INIT = '0,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk_a,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       burst_len,
  input  logic [7:0]       gap_len,
  input  logic [15:0]      num_bursts,
`ifdef CDC_GEN_PRBS_EN
  input  logic             prbs_sel,
`endif
  output logic             data_valid_a,
  output logic [WIDTH-1:0] data_a,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beat_count
);

  gen_state_t       r_state, w_state_nxt;
  logic [7:0]       r_blen, w_blen_nxt;
  logic [7:0]       r_glen, w_glen_nxt;
  logic [15:0]      r_nb, w_nb_nxt;
  logic [7:0]       r_beat, w_beat_nxt;
  logic [7:0]       r_gap, w_gap_nxt;
  logic [15:0]      r_bcnt, w_bcnt_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_last_beat;
  logic             w_last_burst;

  assign w_last_beat  = (r_beat == r_blen - 8'd1);
  assign w_last_burst = (r_nb != 16'd0) && (16'(r_bcnt + 16'd1) == r_nb);

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state_nxt = r_state;
    w_blen_nxt  = r_blen;
    w_glen_nxt  = r_glen;
    w_nb_nxt    = r_nb;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    w_bcnt_nxt  = r_bcnt;
    w_data_nxt  = r_data;
    w_dout_nxt  = r_dout;
    w_count_nxt = r_count;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_blen_nxt  = (burst_len == 8'd0) ? 8'd1 : burst_len;
          w_glen_nxt  = gap_len;
          w_nb_nxt    = num_bursts;
          w_beat_nxt  = 8'd0;
          w_gap_nxt   = 8'd0;
          w_bcnt_nxt  = 16'd0;
          w_data_nxt  = DATA_INIT;
          w_count_nxt = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
        w_dout_nxt  = r_data;
        w_data_nxt  = WIDTH'(r_data + WIDTH'(1));
        w_count_nxt = (&r_count) ? r_count : CNT_W'(r_count + CNT_W'(1));
        if (w_last_beat) begin
          w_beat_nxt = 8'd0;
          w_bcnt_nxt = 16'(r_bcnt + 16'd1);
          if (w_last_burst) begin
            w_state_nxt = DONE;
          end else if (r_glen != 8'd0) begin
            w_gap_nxt   = 8'd0;
            w_state_nxt = GAP;
          end
        end else begin
          w_beat_nxt = 8'(r_beat + 8'd1);
        end
      end
      GAP: begin
        w_busy_nxt = 1'b1;
        if (r_gap == r_glen - 8'd1) begin
          w_gap_nxt   = 8'd0;
          w_state_nxt = BURST;
        end else begin
          w_gap_nxt = 8'(r_gap + 8'd1);
        end
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Abort beats any burst/gap/done transition and freezes data and count.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_data_nxt  = r_data;
      w_dout_nxt  = r_dout;
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst) begin
      r_state <= IDLE;
      r_blen  <= 8'd1;
      r_glen  <= 8'd0;
      r_nb    <= 16'd0;
      r_beat  <= 8'd0;
      r_gap   <= 8'd0;
      r_bcnt  <= 16'd0;
      r_data  <= DATA_INIT;
      r_dout  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blen  <= w_blen_nxt;
      r_glen  <= w_glen_nxt;
      r_nb    <= w_nb_nxt;
      r_beat  <= w_beat_nxt;
      r_gap   <= w_gap_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_data  <= w_data_nxt;
      r_dout  <= w_dout_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef CDC_GEN_PRBS_EN
  logic                  r_psel;
  logic                  w_lfsr_load;
  logic                  w_lfsr_adv;
  logic [PRBS31_LEN-1:0] w_lfsr_state;

  assign w_lfsr_load = (r_state == IDLE) && start && !abort;
  assign w_lfsr_adv  = r_psel && (r_state == BURST) && !abort;

  always_ff @(posedge clk_a) begin
    if (rst) begin
      r_psel <= 1'b0;
    end else if (w_lfsr_load) begin
      r_psel <= prbs_sel;
    end
  end

  cdc_lfsr #(
    .LEN  (PRBS31_LEN),
    .TAPS (PRBS31_TAPS),
    .SEED (PRBS31_SEED)
  ) u_lfsr (
    .clk       (clk_a),
    .rst       (rst),
    .i_load    (w_lfsr_load),
    .i_seed    (PRBS31_SEED),
    .i_advance (w_lfsr_adv),
    .o_state   (w_lfsr_state)
  );

  // LFSR state is itself a register, so the selected data stays registered.
  assign data_a = r_psel ? w_lfsr_state[WIDTH-1:0] : r_dout;
`else
  assign data_a = r_dout;
`endif

  assign data_valid_a = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign beat_count   = r_count;

endmodule

// File: tb/tb_cdc_stream_gen.sv
// Self-checking bench for cdc_stream_gen: per-cycle expected output stream built from
// the burst/gap/count rules, directed corner cases plus randomized runs.
module tb_cdc_stream_gen;

  localparam int unsigned WIDTH   = 8;
  localparam logic [7:0]  DINIT   = 8'hFE;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_a = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [7:0]       burst_len;
  logic [7:0]       gap_len;
  logic [15:0]      num_bursts;
  logic             prbs_sel;
  logic             data_valid_a;
  logic [WIDTH-1:0] data_a;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] beat_count;

  always #5 clk_a = ~clk_a;

  cdc_stream_gen #(
    .WIDTH     (WIDTH),
    .DATA_INIT (DINIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_a        (clk_a),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .burst_len    (burst_len),
    .gap_len      (gap_len),
    .num_bursts   (num_bursts),
`ifdef CDC_GEN_PRBS_EN
    .prbs_sel     (prbs_sel),
`endif
    .data_valid_a (data_valid_a),
    .data_a       (data_a),
    .busy         (busy),
    .done         (done),
    .beat_count   (beat_count)
  );

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         b;
    bit         dn;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   last_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  function automatic logic [30:0] prbs_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  // Expected output stream, one entry per cycle, starting with the first beat cycle.
  task automatic build(input int bl, input int gl, input int nb, input bit psel, input int maxc);
    int          blen;
    int          cnt;
    int          b;
    logic [7:0]  d;
    logic [7:0]  last;
    logic [30:0] lf;
    exp_t        e;
    exp_q.delete();
    blen = (bl == 0) ? 1 : bl;
    d    = DINIT;
    lf   = 31'h1;
    cnt  = 0;
    b    = 0;
    last = 8'h00;
    while (exp_q.size() < maxc) begin
      for (int i = 0; i < blen; i++) begin
        if (psel) begin
          lf   = prbs_step(lf);
          last = lf[7:0];
        end else begin
          last = d;
          d    = d + 8'd1;
        end
        if (cnt < CNT_MAX) cnt++;
        e = '{v: 1'b1, d: last, b: 1'b1, dn: 1'b0, c: cnt};
        exp_q.push_back(e);
      end
      b++;
      if (nb != 0 && b == nb) begin
        e = '{v: 1'b0, d: last, b: 1'b0, dn: 1'b1, c: cnt};
        exp_q.push_back(e);
        break;
      end
      for (int g = 0; g < gl; g++) begin
        e = '{v: 1'b0, d: last, b: 1'b1, dn: 1'b0, c: cnt};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_idle(input string tag, input int cnt);
    check({tag, "_valid"}, 32'(data_valid_a), 32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_count"}, 32'(beat_count),   32'(cnt));
  endtask

  task automatic do_run(input int bl, input int gl, input int nb, input bit psel,
                        input int restart_at, input int abort_at, input int maxc);
    build(bl, gl, nb, psel, maxc);
    burst_len  = 8'(bl);
    gap_len    = 8'(gl);
    num_bursts = 16'(nb);
    prbs_sel   = psel;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("latency_valid", 32'(data_valid_a), 32'd0);
    // Config changes after start must not affect this run.
    burst_len  = 8'($urandom);
    gap_len    = 8'($urandom);
    num_bursts = 16'($urandom);
    prbs_sel   = 1'($urandom);
    last_count = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort", last_count);
        tick();
        check_idle("abort_hold", last_count);
        return;
      end
      if (i == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
      check("valid", 32'(data_valid_a), 32'(exp_q[i].v));
      check("data",  32'(data_a),       32'(exp_q[i].d));
      check("busy",  32'(busy),         32'(exp_q[i].b));
      check("done",  32'(done),         32'(exp_q[i].dn));
      check("count", 32'(beat_count),   32'(exp_q[i].c));
      last_count = exp_q[i].c;
    end
    tick();
    check_idle("post", last_count);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    burst_len  = 8'd3;
    gap_len    = 8'd0;
    num_bursts = 16'd1;
    prbs_sel   = 1'b0;
    repeat (3) tick();
    check_idle("reset", 0);
    check("reset_data", 32'(data_a), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_idle("after_reset", 0);

    do_run(3, 2, 2, 1'b0, -1, -1, 1000);
    do_run(4, 0, 3, 1'b0, -1, -1, 1000);
    do_run(4, 1, 1, 1'b0, -1, -1, 1000);
    do_run(8, 0, 0, 1'b0, -1, 5, 40);
    do_run(2, 0, 1, 1'b0, -1, -1, 1000);
    do_run(3, 1, 3, 1'b0, 4, -1, 1000);
    do_run(8, 0, 3, 1'b0, -1, -1, 1000);
    do_run(0, 0, 2, 1'b0, -1, -1, 1000);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort", last_count);
    tick();
    check_idle("start_abort_hold", last_count);

    // reset during a gap, with start held through reset
    burst_len  = 8'd2;
    gap_len    = 8'd3;
    num_bursts = 16'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("gap_valid", 32'(data_valid_a), 32'd0);
    check("gap_busy",  32'(busy),         32'd1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    check_idle("rst_gap", 0);
    check("rst_gap_data", 32'(data_a), 32'd0);
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_idle("rst_gap_idle", 0);

    for (int r = 0; r < 10; r++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      do_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), 1'b0,
             int'($urandom_range(1, 6)), ab, 1000);
    end

`ifdef CDC_GEN_PRBS_EN
    do_run(4, 0, 1, 1'b1, -1, -1, 1000);
    do_run(3, 2, 2, 1'b1, -1, -1, 1000);
    do_run(3, 0, 1, 1'b0, -1, -1, 1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
